// File: rtl/shift_seq_ctrl.sv
// Sequencer that drives one 8-bit right-shift register as a framed LSB-first
// serial transmitter: parallel word in, LOAD, SHIFT nb bits, CLEAR, inter-frame GAP.
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic                       clk,
    input  logic                       ctrl_rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH):0]     in_nbits,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           sh_q,
    output logic [WIDTH-1:0]           sh_d,
    output logic                       sh_load,
    output logic                       sh_shift,
    output logic                       sh_rst,
    output logic                       ser_valid,
    output logic                       ser_bit,
    input  logic                       ser_ready,
    output logic                       frame_done
);

    localparam int NBW = $clog2(WIDTH) + 1;
    localparam logic [NBW-1:0] NB_FULL  = NBW'(WIDTH);
    localparam logic [3:0]     GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CLEAR = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t           state_q;
    logic [NBW-1:0]   nb_q;
    logic [NBW-1:0]   bcnt_q;
    logic [3:0]       gcnt_q;
    logic [WIDTH-1:0] sh_d_q;
    logic             sh_rst_q;
    logic             in_ready_q;
    logic             sh_load_q;
    logic             ser_valid_q;
    logic             frame_done_q;
    logic [NBW-1:0]   nb_d;
    logic             unused_sh_q_s;

    // Bit count clipping: 0 and anything above WIDTH both mean a full word.
    always_comb begin
        nb_d = in_nbits;
        if ((in_nbits == {NBW{1'b0}}) || (in_nbits > NB_FULL)) begin
            nb_d = NB_FULL;
        end else begin
            nb_d = in_nbits;
        end
    end

    // Frame sequencer; outputs are registered for the state being entered.
    always_ff @(posedge clk or posedge ctrl_rst) begin
        if (ctrl_rst) begin
            state_q      <= ST_IDLE;
            nb_q         <= {NBW{1'b0}};
            bcnt_q       <= {NBW{1'b0}};
            gcnt_q       <= 4'd0;
            sh_d_q       <= {WIDTH{1'b0}};
            sh_rst_q     <= 1'b1;
            in_ready_q   <= 1'b0;
            sh_load_q    <= 1'b0;
            ser_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            sh_rst_q     <= 1'b0;
            sh_load_q    <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        sh_d_q     <= in_data;
                        nb_q       <= nb_d;
                        in_ready_q <= 1'b0;
                        sh_load_q  <= 1'b1;
                        state_q    <= ST_LOAD;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    bcnt_q      <= {NBW{1'b0}};
                    ser_valid_q <= 1'b1;
                    state_q     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (ser_ready) begin
                        bcnt_q <= bcnt_q + NBW'(1);
                        if (bcnt_q == (nb_q - NBW'(1))) begin
                            ser_valid_q  <= 1'b0;
                            sh_rst_q     <= 1'b1;
                            frame_done_q <= 1'b1;
                            state_q      <= ST_CLEAR;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_CLEAR: begin
                    gcnt_q <= 4'd0;
                    if (GAP > 0) begin
                        state_q <= ST_GAP;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gcnt_q == GAP_LAST) begin
                        in_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        gcnt_q <= gcnt_q + 4'd1;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    ser_valid_q <= 1'b0;
                    sh_rst_q    <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Shifting is the only Mealy path: advance exactly when the consumer takes the bit.
    assign sh_shift      = (state_q == ST_SHIFT) && ser_ready;
    assign ser_bit       = sh_q[0];
    assign unused_sh_q_s = ^sh_q[WIDTH-1:1];

    assign in_ready   = in_ready_q;
    assign sh_d       = sh_d_q;
    assign sh_load    = sh_load_q;
    assign sh_rst     = sh_rst_q;
    assign ser_valid  = ser_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with behavioural shifters attached to a GAP=2
// and a GAP=0 instance.
module tb_shift_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       ctrl_rst;
    logic       in_valid, in_ready, sh_load, sh_shift, sh_rst, ser_valid, ser_bit, ser_ready, frame_done;
    logic [7:0] in_data, sh_q, sh_d;
    logic [3:0] in_nbits;

    logic       in_valid0, in_ready0, sh_load0, sh_shift0, sh_rst0, ser_valid0, ser_bit0, ser_ready0, frame_done0;
    logic [7:0] in_data0, sh_q0, sh_d0;
    logic [3:0] in_nbits0;

    int n_pass  = 0;
    int n_total = 0;

    shift_seq_ctrl #(.WIDTH(8), .GAP(2)) u_dut (
        .clk(clk), .ctrl_rst(ctrl_rst), .in_valid(in_valid), .in_data(in_data),
        .in_nbits(in_nbits), .in_ready(in_ready), .sh_q(sh_q), .sh_d(sh_d),
        .sh_load(sh_load), .sh_shift(sh_shift), .sh_rst(sh_rst), .ser_valid(ser_valid),
        .ser_bit(ser_bit), .ser_ready(ser_ready), .frame_done(frame_done)
    );

    shift_seq_ctrl #(.WIDTH(8), .GAP(0)) u_dut0 (
        .clk(clk), .ctrl_rst(ctrl_rst), .in_valid(in_valid0), .in_data(in_data0),
        .in_nbits(in_nbits0), .in_ready(in_ready0), .sh_q(sh_q0), .sh_d(sh_d0),
        .sh_load(sh_load0), .sh_shift(sh_shift0), .sh_rst(sh_rst0), .ser_valid(ser_valid0),
        .ser_bit(ser_bit0), .ser_ready(ser_ready0), .frame_done(frame_done0)
    );

    // Right-shift registers: clear has priority over load, load over shift.
    always_ff @(posedge clk) begin
        if (sh_rst)        sh_q <= 8'h00;
        else if (sh_load)  sh_q <= sh_d;
        else if (sh_shift) sh_q <= {1'b0, sh_q[7:1]};
        if (sh_rst0)        sh_q0 <= 8'h00;
        else if (sh_load0)  sh_q0 <= sh_d0;
        else if (sh_shift0) sh_q0 <= {1'b0, sh_q0[7:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic offer(input logic [7:0] d, input logic [3:0] n);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_nbits  = n;
        ser_ready = 1'b1;
    endtask

    // Follows one frame from the LOAD cycle (k=0) until in_ready returns.
    task automatic run_frame(input logic [63:0] mask, input logic nv, input logic [7:0] nd,
                             input logic [3:0] nn, output logic [15:0] bits, output int nb,
                             output int cycles, output int fd, output int vcyc,
                             output int stall_shift, output int load_at,
                             output logic [7:0] q_after, output int overlap);
        logic seen_fd, got_q;
        bits = 16'h0; nb = 0; cycles = -1; fd = 0; vcyc = 0; stall_shift = 0;
        load_at = -1; q_after = 8'hEE; overlap = 0; seen_fd = 1'b0; got_q = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            ser_ready = mask[k];
            if (k == 0) begin
                in_valid = nv; in_data = nd; in_nbits = nn;
            end
            #1;
            if (seen_fd && !got_q) begin q_after = sh_q; got_q = 1'b1; end
            if (frame_done) begin fd++; seen_fd = 1'b1; end
            if (sh_load && load_at < 0) load_at = k;
            if (sh_load && sh_shift) overlap++;
            if (ser_valid) vcyc++;
            if (ser_valid && !ser_ready && sh_shift) stall_shift++;
            if (ser_valid && ser_ready && nb < 16) begin bits[nb] = ser_bit; nb++; end
            if (in_ready) begin cycles = k; break; end
        end
    endtask

    logic [15:0] bits;
    logic [7:0]  q_after;
    int nb, cycles, fd, vcyc, stall_shift, load_at, overlap, fd_rst;

    initial begin
        ctrl_rst = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; in_nbits = 4'd0; ser_ready = 1'b0;
        in_valid0 = 1'b0; in_data0 = 8'h00; in_nbits0 = 4'd0; ser_ready0 = 1'b0;

        // Reset release
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sh_rst", 32'(sh_rst), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_outs", 32'({sh_load, sh_shift, ser_valid, ser_bit, frame_done}), 32'd0);
        chk("rst_sh_d", 32'(sh_d), 32'h00);
        chk("rst_sh_q", 32'(sh_q), 32'h00);
        ctrl_rst = 1'b0;
        #1;
        chk("rel_sh_rst_hold", 32'(sh_rst), 32'd1);
        chk("rel_in_ready_hold", 32'(in_ready), 32'd0);
        @(negedge clk); #1;
        chk("rel_sh_rst_drop", 32'(sh_rst), 32'd0);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_in_ready0", 32'(in_ready0), 32'd1);

        // Full byte, no stalls
        offer(8'hA5, 4'd0);
        run_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'h00, 4'd0, bits, nb, cycles, fd, vcyc,
                  stall_shift, load_at, q_after, overlap);
        chk("a5_bits", 32'(bits), 32'h00A5);
        chk("a5_nbits", 32'(nb), 32'd8);
        chk("a5_frame_done", 32'(fd), 32'd1);
        chk("a5_cycles", 32'(cycles), 32'd12);
        chk("a5_load_at", 32'(load_at), 32'd0);
        chk("a5_q_cleared", 32'(q_after), 32'h00);
        chk("a5_overlap", 32'(overlap), 32'd0);

        // Partial frame, two stall cycles before the second bit
        offer(8'h3C, 4'd3);
        run_frame(~64'h0000_0000_0000_000C, 1'b0, 8'h00, 4'd0, bits, nb, cycles, fd, vcyc,
                  stall_shift, load_at, q_after, overlap);
        chk("3c_bits", 32'(bits), 32'h0004);
        chk("3c_nbits", 32'(nb), 32'd3);
        chk("3c_valid_cycles", 32'(vcyc), 32'd5);
        chk("3c_stall_shift", 32'(stall_shift), 32'd0);
        chk("3c_cycles", 32'(cycles), 32'd9);
        chk("3c_frame_done", 32'(fd), 32'd1);

        // Clipping, then a second word offered continuously
        offer(8'h96, 4'd12);
        run_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'hFF, 4'd2, bits, nb, cycles, fd, vcyc,
                  stall_shift, load_at, q_after, overlap);
        chk("clip_bits", 32'(bits), 32'h0096);
        chk("clip_nbits", 32'(nb), 32'd8);
        chk("clip_cycles", 32'(cycles), 32'd12);
        chk("clip_sh_d_stable", 32'(sh_d), 32'h96);
        chk("clip_overlap", 32'(overlap), 32'd0);
        run_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'h00, 4'd0, bits, nb, cycles, fd, vcyc,
                  stall_shift, load_at, q_after, overlap);
        chk("b2b_load_at", 32'(load_at), 32'd0);
        chk("b2b_sh_d", 32'(sh_d), 32'hFF);
        chk("b2b_bits", 32'(bits), 32'h0003);
        chk("b2b_nbits", 32'(nb), 32'd2);
        chk("b2b_cycles", 32'(cycles), 32'd6);
        chk("b2b_overlap", 32'(overlap), 32'd0);

        // Reset mid-frame after four bits of 0x81
        offer(8'h81, 4'd0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        @(negedge clk);
        ctrl_rst = 1'b1;
        #1;
        chk("mid_ser_valid", 32'(ser_valid), 32'd0);
        chk("mid_sh_rst", 32'(sh_rst), 32'd1);
        chk("mid_in_ready", 32'(in_ready), 32'd0);
        fd_rst = 0;
        if (frame_done) fd_rst++;
        repeat (2) begin
            @(negedge clk); #1;
            if (frame_done) fd_rst++;
        end
        ctrl_rst = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            if (frame_done) fd_rst++;
        end
        chk("mid_no_frame_done", 32'(fd_rst), 32'd0);
        chk("mid_in_ready_back", 32'(in_ready), 32'd1);
        chk("mid_sh_q_cleared", 32'(sh_q), 32'h00);
        offer(8'h01, 4'd1);
        run_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'h00, 4'd0, bits, nb, cycles, fd, vcyc,
                  stall_shift, load_at, q_after, overlap);
        chk("post_bits", 32'(bits), 32'h0001);
        chk("post_nbits", 32'(nb), 32'd1);
        chk("post_cycles", 32'(cycles), 32'd5);
        chk("post_frame_done", 32'(fd), 32'd1);

        // GAP = 0 instance, single-bit frame
        @(negedge clk);
        in_valid0 = 1'b1; in_data0 = 8'h01; in_nbits0 = 4'd1; ser_ready0 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        #1;
        chk("g0_load", 32'(sh_load0), 32'd1);
        chk("g0_in_ready_load", 32'(in_ready0), 32'd0);
        @(negedge clk); #1;
        chk("g0_valid", 32'(ser_valid0), 32'd1);
        chk("g0_bit", 32'(ser_bit0), 32'd1);
        @(negedge clk); #1;
        chk("g0_frame_done", 32'(frame_done0), 32'd1);
        chk("g0_in_ready_clear", 32'(in_ready0), 32'd0);
        @(negedge clk); #1;
        chk("g0_in_ready", 32'(in_ready0), 32'd1);
        chk("g0_frame_done_end", 32'(frame_done0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencer for the 8-bit right-shift register (`Shift_En`/`Load_En`/`shift_rst`/`D`/`Q`) that turns it into a framed LSB-first serial transmitter.
- Accepts a parallel word plus bit count over a valid/ready handshake.
- Loads the word into the shifter and streams `nbits` bits from `Q[0]` under a downstream valid/ready handshake.
- Clears the shifter and enforces an inter-frame gap.
- Sits between the parallel producer and the serial consumer; it owns every control input of one shifter instance.

## Interface
- `WIDTH`, 8: shifter data width; must equal the connected shifter's width.
- `GAP`, 2: idle cycles after each frame before `in_ready` reasserts; legal range 0..15.
- `clk` input 1: single clock, rising edge.
- `ctrl_rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: producer has a word.
- `in_data` input WIDTH: word to transmit, bit 0 first.
- `in_nbits` input $clog2(WIDTH)+1: bits to send. 0 means WIDTH; values above WIDTH are clipped to WIDTH.
- `in_ready` output 1: controller accepts a word this cycle.
- `sh_q` input WIDTH: shifter `Q`.
- `sh_d` output WIDTH: shifter `D`; holds the captured word.
- `sh_load` output 1: drives shifter `Load_En`.
- `sh_shift` output 1: drives shifter `Shift_En`.
- `sh_rst` output 1: drives shifter `shift_rst`; must come directly from a flop, with no decode logic between flop and port.
- `ser_valid` output 1: `ser_bit` is valid.
- `ser_bit` output 1: current serial bit, equal to `sh_q[0]`.
- `ser_ready` input 1: consumer takes `ser_bit` this cycle.
- `frame_done` output 1: one-cycle pulse when a frame completes.

## Operation
- States are IDLE, LOAD, SHIFT, CLEAR and GAP.
- Reset values:
  - State is IDLE; the bit counter, gap counter and `sh_d` are 0.
  - The `sh_rst` flop resets to 1, so the shifter is cleared during reset. `sh_rst` drops at the first rising edge after `ctrl_rst` deasserts.
  - `in_ready` is 0 while `sh_rst` is 1. All other outputs are 0.
- IDLE:
  - `in_ready` = 1.
  - When `in_valid && in_ready` at an edge: capture `in_data` into `sh_d`, capture the clipped `in_nbits` into `nb`, go to LOAD.
- LOAD (1 cycle): `sh_load` = 1, `sh_shift` = 0. The shifter holds the word after this edge. Clear `bcnt` and go to SHIFT.
- SHIFT:
  - `ser_valid` = 1, `ser_bit` = `sh_q[0]`.
  - `sh_shift` = `ser_ready`; this is the only Mealy output.
  - On each edge with `ser_ready` = 1, `bcnt` increments.
  - When `ser_ready` is accepted with `bcnt == nb-1`, go to CLEAR.
  - With `ser_ready` = 0 the shifter holds: no shift, and the same bit stays presented.
- CLEAR (1 cycle): the `sh_rst` flop is 1 during this cycle and `frame_done` = 1. Go to GAP if `GAP > 0`, else to IDLE.
- GAP: runs `GAP` cycles with `in_ready` = 0, then goes to IDLE.
- Invariants:
  - `sh_load` and `sh_shift` are never 1 in the same cycle.
  - `in_ready` is 0 outside IDLE, and `in_valid` is ignored there.
  - `sh_d` is stable from capture until the next capture.
- `ctrl_rst` mid-frame aborts immediately and produces no `frame_done`. The shifter is cleared through `sh_rst`.
- `in_data`, `in_nbits` and `in_valid` may change freely while `in_ready` = 0.

## Timing
- Acceptance at edge E0. LOAD runs E0–E1. First `ser_valid` appears in the cycle after E1, so the first bit is visible 2 cycles after acceptance.
- Without stalls, a frame occupies 1 (LOAD) + `nb` (SHIFT) + 1 (CLEAR) + `GAP` cycles from acceptance edge to `in_ready` = 1.
  - WIDTH = 8, `nb` = 8, GAP = 2: `in_ready` reasserts 12 cycles after the acceptance edge.
- Every cycle of `ser_ready` = 0 in SHIFT adds exactly one cycle to the frame.
- `frame_done` is high in exactly one cycle per completed frame: the CLEAR cycle.
- After the CLEAR edge, `sh_q` reads 0 by the next cycle.

## Test plan
- Reset release:
  - Stimulus: assert `ctrl_rst` for 3 cycles, then release.
  - Required: `sh_rst` = 1 throughout reset and 0 one edge after release; `in_ready` = 0 while `sh_rst` = 1 and 1 from the next cycle.
  - Required: all other outputs 0, and `sh_q` = 0x00.
- Full byte, no stalls:
  - Stimulus: `in_data` = 0xA5, `in_nbits` = 0, `ser_ready` held at 1.
  - Required: `ser_bit` sequence 1,0,1,0,0,1,0,1 on 8 consecutive `ser_valid` cycles, then a `frame_done` pulse.
  - Required: `in_ready` returns 12 cycles after acceptance.
- Partial frame with stalls:
  - Stimulus: `in_data` = 0x3C, `in_nbits` = 3; `ser_ready` low for 2 cycles before the second bit.
  - Required: bits 0,0,1; the second bit is held for 3 cycles; `sh_shift` = 0 on the stalled cycles; frame is 2 cycles longer.
- Clipping and back-to-back:
  - Stimulus: `in_nbits` = 12, then a second word 0xFF offered continuously with `in_valid` = 1.
  - Required: first frame sends 8 bits.
  - Required: second word is accepted exactly on the first IDLE cycle after GAP; `in_valid` is ignored before that; `sh_load` and `sh_shift` are never both 1.
- Reset mid-frame:
  - Stimulus: assert `ctrl_rst` after bit 4 of 0x81.
  - Required: `ser_valid` = 0 immediately, `sh_rst` = 1, no `frame_done`.
  - Required: after release, a new 0x01 frame with `in_nbits` = 1 sends the single bit 1.
- GAP = 0 configuration:
  - Stimulus: instance with GAP = 0, frame with `in_nbits` = 1.
  - Required: `in_ready` = 1 in the cycle after CLEAR, with a total of 3 cycles from acceptance to `in_ready`.
